// File: rtl/jt12_regwr_pkg.sv
// jt12_regwr_pkg: state encoding, defaults and small helpers
// shared by the YM2612 register-write sequencer.
package jt12_regwr_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AWR  = 3'd1,
    AGAP = 3'd2,
    DWR  = 3'd3,
    BUSY = 3'd4
  } state_t;

  localparam int WR_CEN_DEF    = 2;
  localparam int GAP_CEN_DEF   = 2;
  localparam int POLL_BUSY_DEF = 1;
  localparam int TIMEOUT_DEF   = 255;

  // Phase counters count down to zero, so load n-1.
  function automatic logic [3:0] phase_load(input int n);
    return 4'(n - 1);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/jt12_regwr.sv
// jt12_regwr: sequences one YM2612 register write
// (address strobe, gap, data strobe, optional busy poll).
module jt12_regwr
  import jt12_regwr_pkg::*;
#(
  parameter int WR_CEN    = WR_CEN_DEF,
  parameter int GAP_CEN   = GAP_CEN_DEF,
  parameter int POLL_BUSY = POLL_BUSY_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_part,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_val,
  output logic [7:0] ym_din,
  output logic [1:0] ym_addr,
  output logic       ym_cs_n,
  output logic       ym_wr_n,
  input  logic [7:0] ym_dout,
  output logic       done,
  output logic       timeout
);

  localparam logic [3:0] WR_LD  = phase_load(WR_CEN);
  localparam logic [3:0] GAP_LD = phase_load(GAP_CEN);
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  state_t     state;
  logic       part_q;
  logic [7:0] val_q;
  logic [3:0] cnt;
  logic [7:0] bcnt;
  logic [7:0] bcnt_nx;
  logic       unused_dout;

  assign bcnt_nx     = sat_inc(bcnt);
  assign unused_dout = ^ym_dout[6:0];

  always_ff @(posedge clk) begin
    done    <= 1'b0;
    timeout <= 1'b0;
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      ym_cs_n   <= 1'b1;
      ym_wr_n   <= 1'b1;
      ym_addr   <= 2'd0;
      ym_din    <= 8'd0;
      part_q    <= 1'b0;
      val_q     <= 8'd0;
      cnt       <= 4'd0;
      bcnt      <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            part_q    <= req_part;
            val_q     <= req_val;
            ym_addr   <= {req_part, 1'b0};
            ym_din    <= req_reg;
            ym_cs_n   <= 1'b0;
            ym_wr_n   <= 1'b0;
            cnt       <= WR_LD;
            req_ready <= 1'b0;
            state     <= AWR;
          end
        end
        AWR: if (cen) begin
          if (cnt == 4'd0) begin
            ym_cs_n <= 1'b1;
            ym_wr_n <= 1'b1;
            cnt     <= GAP_LD;
            state   <= AGAP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        AGAP: if (cen) begin
          if (cnt == 4'd0) begin
            ym_addr <= {part_q, 1'b1};
            ym_din  <= val_q;
            ym_cs_n <= 1'b0;
            ym_wr_n <= 1'b0;
            cnt     <= WR_LD;
            state   <= DWR;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DWR: if (cen) begin
          if (cnt == 4'd0) begin
            ym_cs_n <= 1'b1;
            ym_wr_n <= 1'b1;
            if (POLL_BUSY != 0) begin
              bcnt  <= 8'd0;
              state <= BUSY;
            end else begin
              ym_addr   <= 2'd0;
              ym_din    <= 8'd0;
              req_ready <= 1'b1;
              done      <= 1'b1;
              state     <= IDLE;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        BUSY: if (cen) begin
          bcnt <= bcnt_nx;
          // bcnt==0 marks the first tick: busy is not yet valid there
          if (bcnt != 8'd0 && !ym_dout[7]) begin
            ym_addr   <= 2'd0;
            ym_din    <= 8'd0;
            req_ready <= 1'b1;
            done      <= 1'b1;
            state     <= IDLE;
          end else if (bcnt_nx >= TO_LIM) begin
            ym_addr   <= 2'd0;
            ym_din    <= 8'd0;
            req_ready <= 1'b1;
            timeout   <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/jt12_regwr.md
JT12_REGWR -- requirements
Module: jt12_regwr

Interface
REQ-001 SHALL have parameter WR_CEN, default 2, meaning the write-strobe width in cen ticks (legal range 1..15).
REQ-002 SHALL have parameter GAP_CEN, default 2, meaning the idle cen ticks between the address write and the data write (legal range 1..15).
REQ-003 SHALL have parameter POLL_BUSY, default 1, meaning that after the data write it waits until the chip busy flag clears.
REQ-004 SHALL have parameter TIMEOUT, default 255, meaning the maximum cen ticks spent in busy-wait (8-bit).
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port cen, input, 1 bit: clock enable shared with the chip.
REQ-008 SHALL have port req_valid, input, 1 bit: a register-write request is presented.
REQ-009 SHALL have port req_ready, output, 1 bit: the block accepts a request.
REQ-010 SHALL have port req_part, input, 1 bit: 0 selects part I, 1 selects part II.
REQ-011 SHALL have port req_reg, input, 8 bits: register number.
REQ-012 SHALL have port req_val, input, 8 bits: register value.
REQ-013 SHALL have port ym_din, output, 8 bits: data bus driven to the chip.
REQ-014 SHALL have port ym_addr, output, 2 bits: chip address pins.
REQ-015 SHALL have port ym_cs_n, output, 1 bit: chip select, active low.
REQ-016 SHALL have port ym_wr_n, output, 1 bit: write strobe, active low.
REQ-017 SHALL have port ym_dout, input, 8 bits: chip status; bit 7 is busy.
REQ-018 SHALL have port done, output, 1 bit: one-clk pulse when a request completes.
REQ-019 SHALL have port timeout, output, 1 bit: one-clk pulse when the busy-wait gives up.

Function
REQ-020 SHALL use states IDLE, AWR, AGAP, DWR, BUSY.
REQ-021 SHALL assert req_ready only in IDLE; a request is accepted on any clk edge with req_valid&&req_ready, independent of cen.
REQ-022 SHALL latch part/reg/val at acceptance and ignore later changes to the req_* inputs.
REQ-023 SHALL in IDLE drive ym_cs_n=1, ym_wr_n=1, ym_addr=0, ym_din=0.
REQ-024 SHALL in AWR drive ym_addr={part,0}, ym_din=reg, ym_cs_n=0, ym_wr_n=0 for exactly WR_CEN cen ticks.
REQ-025 SHALL in AGAP drive ym_cs_n=1 and ym_wr_n=1, holding ym_addr/ym_din, for GAP_CEN cen ticks.
REQ-026 SHALL in DWR drive ym_addr={part,1}, ym_din=val, ym_cs_n=0, ym_wr_n=0 for WR_CEN cen ticks.
REQ-027 SHALL, when POLL_BUSY=0, go from DWR to IDLE and pulse done in the first clk of IDLE.
REQ-028 SHALL, when POLL_BUSY=1, enter BUSY with ym_cs_n=ym_wr_n=1 and skip the first cen tick, because the chip raises busy late.
REQ-029 SHALL in BUSY, from the second cen tick on, sample ym_dout[7] on each cen tick; when it reads 0, go to IDLE and pulse done.
REQ-030 SHALL, if TIMEOUT cen ticks elapse in BUSY without the busy flag clearing, go to IDLE and pulse timeout (not done).
REQ-031 SHALL hold every state's outputs with cen=0: state counters advance only on cen ticks.
REQ-032 SHALL use a 4-bit tick down-counter for the AWR/AGAP/DWR phases.
REQ-033 SHALL use an 8-bit tick counter for BUSY that saturates and does not wrap.
REQ-034 SHALL allow a new request to be accepted in the same clk in which done or timeout pulses.

Reset
REQ-035 SHALL on rst move to IDLE on the next edge, at any point of an operation, and abandon any partial write.
REQ-036 SHALL during rst drive ym_cs_n=1, ym_wr_n=1, ym_addr=0, ym_din=0, done=0, timeout=0, req_ready=0.
REQ-037 SHALL raise req_ready on the first clk after rst deasserts.

Structure
REQ-038 SHALL take the state encoding constants and the default parameter values from a shared package, jt12_regwr_pkg.
REQ-039 SHALL be a single module with no sub-module, since the counters are trivial.

Verification
REQ-040 SHALL cover this case (cen=1, POLL_BUSY=0): request part 0, reg 0x28, value 0xF0 accepted at cycle 0 -> cs_n/wr_n low in cycles 1-2 with addr=0, din=0x28; high in cycles 3-4; low in cycles 5-6 with addr=1, din=0xF0; done in cycle 7.
REQ-041 SHALL cover this case: part 1, reg 0xB4, value 0xC0 -> ym_addr=2 then 3.
REQ-042 SHALL cover this case: POLL_BUSY=1 with the chip model holding busy for 20 ticks -> done exactly 1 clk after the first cen tick sampling busy=0; no timeout.
REQ-043 SHALL cover this case: busy stuck at 1 with TIMEOUT=255 -> timeout pulse after 255 ticks in BUSY; done never asserts.
REQ-044 SHALL cover this case: cen toggling 1/0 -> each strobe phase lasts 4 clk.
REQ-045 SHALL cover this case: rst asserted mid-DWR -> next clk cs_n=wr_n=1, no done; after release req_ready=1 and a new request completes normally.
